// File: rtl/bcd_addsub_seq_if.sv
// Handshake and operand/result bundle for the digit-serial packed-BCD adder/subtractor.
// Source side drives operands (master); the arithmetic unit is the slave.
interface bcd_addsub_seq_if #(
    parameter int DIGITS = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  op;
    logic [4*DIGITS-1:0]   a;
    logic [4*DIGITS-1:0]   b;
    logic                  cin;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   sum;
    logic                  cout;
    logic                  err;

    modport master (
        output in_valid, op, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, err
    );

    modport slave (
        input  in_valid, op, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, err
    );
endinterface

// File: rtl/bcd_addsub_seq.sv
// Multi-digit packed-BCD adder/subtractor, one digit per clock LSD first.
// Subtraction uses nine's complement of B with an inverted carry-in (ten's complement).
module bcd_addsub_seq #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    bcd_addsub_seq_if.slave     bus
);
    localparam int W  = 4 * DIGITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic digit_bad(input logic [3:0] d);
        return (d > 4'd9);
    endfunction

    function automatic logic [3:0] nines_comp(input logic [3:0] d);
        return 4'd9 - d;
    endfunction

    state_t          r_state;
    state_t          w_state_next;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic            r_op;
    logic            r_c;
    logic [CW-1:0]   r_cnt;
    logic            r_err_flag;
    logic [W-1:0]    r_res;
    logic [W-1:0]    r_sum;
    logic            r_cout;
    logic            r_err;

    logic [3:0]      w_ad;
    logic [3:0]      w_bd;
    logic [4:0]      w_t;
    logic [3:0]      w_digit;
    logic            w_c_next;
    logic [W-1:0]    w_res_next;
    logic            w_err_next;
    logic            w_last;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    w_state_next = S_RUN;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end else begin
                    w_state_next = S_RUN;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_DONE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // One-digit BCD add; t+6 mod 16 equals t-10 for the corrected digit
    always_comb begin
        w_ad       = r_a[3:0];
        w_bd       = r_op ? nines_comp(r_b[3:0]) : r_b[3:0];
        w_t        = {1'b0, w_ad} + {1'b0, w_bd} + {4'd0, r_c};
        w_digit    = w_t[3:0];
        w_c_next   = 1'b0;
        if (w_t > 5'd9) begin
            w_digit  = w_t[3:0] + 4'd6;
            w_c_next = 1'b1;
        end else begin
            w_digit  = w_t[3:0];
            w_c_next = 1'b0;
        end
        w_res_next = r_res;
        w_res_next[{r_cnt, 2'b00} +: 4] = w_digit;
        w_err_next = r_err_flag | digit_bad(r_a[3:0]) | digit_bad(r_b[3:0]);
        w_last     = (r_cnt == CW'(DIGITS - 1));
    end

    // Operand latch, digit sequencing and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a        <= '0;
            r_b        <= '0;
            r_op       <= 1'b0;
            r_c        <= 1'b0;
            r_cnt      <= '0;
            r_err_flag <= 1'b0;
            r_res      <= '0;
            r_sum      <= '0;
            r_cout     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_a        <= bus.a;
                        r_b        <= bus.b;
                        r_op       <= bus.op;
                        r_c        <= bus.op ? ~bus.cin : bus.cin;
                        r_cnt      <= '0;
                        r_err_flag <= 1'b0;
                        r_res      <= '0;
                    end
                end
                S_RUN: begin
                    r_a        <= r_a >> 4;
                    r_b        <= r_b >> 4;
                    r_c        <= w_c_next;
                    r_res      <= w_res_next;
                    r_err_flag <= w_err_next;
                    r_cnt      <= r_cnt + CW'(1);
                    // Results publish on the last digit; an invalid digit forces zeros
                    if (w_last) begin
                        r_sum  <= w_err_next ? '0 : w_res_next;
                        r_cout <= w_err_next ? 1'b0 : (r_op ? ~w_c_next : w_c_next);
                        r_err  <= w_err_next;
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
    assign bus.err       = r_err;
endmodule
